// File: rtl/debounce_pkg.sv
// Shared types and default 6 MHz timing constants for the debounce_rpt button conditioner.
package debounce_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StWaitHold = 2'b01,
        StRepeat   = 2'b10
    } hold_state_e;

    localparam int unsigned DEF_BTN_WIDTH     = 5;
    localparam int unsigned DEF_SYNC_STAGES   = 2;
    localparam int unsigned DEF_STABLE_CYCLES = 32768;
    localparam int unsigned DEF_HOLD_CYCLES   = 3000000;
    localparam int unsigned DEF_REPEAT_CYCLES = 600000;
    localparam int unsigned DEF_CNT_W         = 22;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One button channel: stable-count debounce, press/release pulses and, when
// DEBOUNCE_REPEAT_EN is defined, the long-press hold/auto-repeat FSM.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_sync,
    output logic btn_out,
    output logic btn_press,
    output logic btn_release,
    output logic btn_hold,
    output logic btn_repeat
);

    if (STABLE_CYCLES < 2 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2 ||
        $clog2(max3(STABLE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)) > CNT_W) begin : g_bad_cfg
        $error("debounce_chan: timing parameters below 2 or too wide for CNT_W");
    end

    localparam logic [CNT_W-1:0] StableMax = CNT_W'(STABLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_s_q, cnt_s_d;
    logic             out_q, out_d;
    logic             out_dly_q;

    // Any cycle where the synchronized level agrees with the output restarts qualification.
    always_comb begin
        cnt_s_d = '0;
        out_d   = out_q;
        if (btn_sync != out_q) begin
            if (cnt_s_q == StableMax) begin
                out_d = btn_sync;
            end else begin
                cnt_s_d = cnt_s_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_s_q   <= '0;
            out_q     <= 1'b0;
            out_dly_q <= 1'b0;
        end else begin
            cnt_s_q   <= cnt_s_d;
            out_q     <= out_d;
            out_dly_q <= out_q;
        end
    end

    assign btn_out     = out_q;
    assign btn_press   = out_q & ~out_dly_q;
    assign btn_release = ~out_q & out_dly_q;

`ifdef DEBOUNCE_REPEAT_EN
    localparam logic [CNT_W-1:0] HoldMax   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RepeatMax = CNT_W'(REPEAT_CYCLES - 1);

    hold_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_h_q, cnt_h_d;
    logic             rpt_q, rpt_d;

    always_comb begin
        state_d = state_q;
        cnt_h_d = cnt_h_q;
        rpt_d   = rpt_q;
        unique case (state_q)
            StIdle: begin
                if (out_q) begin
                    state_d = StWaitHold;
                    cnt_h_d = CNT_W'(1);
                end
            end
            StWaitHold: begin
                if (!out_q) begin
                    state_d = StIdle;
                end else if (cnt_h_q == HoldMax) begin
                    state_d = StRepeat;
                    cnt_h_d = '0;
                    rpt_d   = 1'b1;
                end else begin
                    cnt_h_d = cnt_h_q + CNT_W'(1);
                end
            end
            StRepeat: begin
                if (!out_q) begin
                    state_d = StIdle;
                    rpt_d   = 1'b0;
                end else if (cnt_h_q == RepeatMax) begin
                    cnt_h_d = '0;
                    rpt_d   = 1'b1;
                end else begin
                    cnt_h_d = cnt_h_q + CNT_W'(1);
                    rpt_d   = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_h_d = '0;
                rpt_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_h_q <= '0;
            rpt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_h_q <= cnt_h_d;
            rpt_q   <= rpt_d;
        end
    end

    // Gating with the live level lets a release suppress a repeat due in the same cycle.
    assign btn_hold   = (state_q == StRepeat) & out_q;
    assign btn_repeat = rpt_q & out_q;
`else
    assign btn_hold   = 1'b0;
    assign btn_repeat = 1'b0;
`endif

endmodule

// File: rtl/debounce_rpt.sv
// Multi-channel push-button conditioner: input synchronizer plus one debounce_chan per button.
// Hold/auto-repeat outputs are only generated when DEBOUNCE_REPEAT_EN is defined.
module debounce_rpt
    import debounce_pkg::*;
#(
    parameter int unsigned BTN_WIDTH     = DEF_BTN_WIDTH,
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BTN_WIDTH-1:0] btn_in,
    output logic [BTN_WIDTH-1:0] btn_out,
    output logic [BTN_WIDTH-1:0] btn_press,
    output logic [BTN_WIDTH-1:0] btn_release,
    output logic [BTN_WIDTH-1:0] btn_hold,
    output logic [BTN_WIDTH-1:0] btn_repeat
);

    if (BTN_WIDTH < 1 || SYNC_STAGES < 2) begin : g_bad_cfg
        $error("debounce_rpt: BTN_WIDTH must be >=1 and SYNC_STAGES >=2");
    end

    // Stage 0 captures the raw asynchronous levels.
    logic [SYNC_STAGES-1:0][BTN_WIDTH-1:0] sync_q;
    logic [BTN_WIDTH-1:0]                  btn_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign btn_sync = sync_q[SYNC_STAGES-1];

    for (genvar i = 0; i < BTN_WIDTH; i++) begin : g_chan
        debounce_chan #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .CNT_W        (CNT_W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .btn_sync   (btn_sync[i]),
            .btn_out    (btn_out[i]),
            .btn_press  (btn_press[i]),
            .btn_release(btn_release[i]),
            .btn_hold   (btn_hold[i]),
            .btn_repeat (btn_repeat[i])
        );
    end

endmodule
